// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the integer register file write ports.
// Optional post-reset zeroing sweep of x1..x31 when REGFILE_INIT_SWEEP_EN is defined.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned NR_REQ         = 4,
    parameter int unsigned NR_WRITE_PORTS = 2
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NR_REQ-1:0]                             req_valid_i,
    output logic [NR_REQ-1:0]                             req_ready_o,
    input  logic [NR_REQ-1:0][4:0]                        req_waddr_i,
    input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]             req_wdata_i,
    output logic [NR_WRITE_PORTS-1:0][4:0]                waddr_o,
    output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]     wdata_o,
    output logic [NR_WRITE_PORTS-1:0]                     we_o,
    output logic                                          busy_o
);

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned IDX_W     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int unsigned LAST_ADDR = 31;

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [DATA_WIDTH-1:0] data;
    } slot_t;

    idx_t                      rr_ptr_q;
    idx_t                      rr_next_c;
    idx_t                      last_grant_c;
    logic                      grant_any_c;
    logic                      run_c;
    logic [NR_REQ-1:0]         ready_c;
    logic [NR_WRITE_PORTS-1:0] slot_used_c;
    slot_t                     slot_c [NR_WRITE_PORTS];

`ifdef REGFILE_INIT_SWEEP_EN
    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    assign run_c  = (state_q == ST_RUN);
    assign busy_o = busy_q;
`else
    assign run_c  = 1'b1;
    assign busy_o = 1'b0;
`endif

    // Scan requesters from rr_ptr; x0 writes are absorbed without a slot,
    // same-address writes behind an earlier grant wait for the next cycle.
    always_comb begin : grant_scan
        idx_t k;
        logic conflict;
        logic placed;
        k            = '0;
        conflict     = 1'b0;
        placed       = 1'b0;
        ready_c      = '0;
        slot_used_c  = '0;
        grant_any_c  = 1'b0;
        last_grant_c = '0;
        for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
            slot_c[p] = '0;
        end
        if (run_c) begin
            for (int j = 0; j < int'(NR_REQ); j++) begin
                k        = IDX_W'((int'(rr_ptr_q) + j) % int'(NR_REQ));
                conflict = 1'b0;
                placed   = 1'b0;
                for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
                    if (slot_used_c[p] && (slot_c[p].addr == req_waddr_i[k])) begin
                        conflict = 1'b1;
                    end
                end
                if (req_valid_i[k]) begin
                    if (req_waddr_i[k] == '0) begin
                        ready_c[k] = 1'b1;
                    end else if (!conflict) begin
                        for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
                            if (!slot_used_c[p] && !placed) begin
                                placed         = 1'b1;
                                slot_used_c[p] = 1'b1;
                                slot_c[p].addr = req_waddr_i[k];
                                slot_c[p].data = req_wdata_i[k];
                                ready_c[k]     = 1'b1;
                                grant_any_c    = 1'b1;
                                last_grant_c   = k;
                            end
                        end
                    end
                end
            end
        end
    end

    assign rr_next_c   = (last_grant_c == IDX_W'(NR_REQ - 1)) ? '0 : last_grant_c + IDX_W'(1);
    assign req_ready_o = ready_c & {NR_REQ{rst_ni}};

    // Sequencer state and registered write-port drive.
    always_ff @(posedge clk_i or negedge rst_ni) begin : seq_regs
        if (!rst_ni) begin
            we_o     <= '0;
            waddr_o  <= '0;
            wdata_o  <= '0;
            rr_ptr_q <= '0;
`ifdef REGFILE_INIT_SWEEP_EN
            state_q  <= ST_INIT;
            cnt_q    <= ADDR_W'(1);
            busy_q   <= 1'b1;
`endif
        end else begin
`ifdef REGFILE_INIT_SWEEP_EN
            if (state_q == ST_INIT) begin
                we_o       <= NR_WRITE_PORTS'(1);
                waddr_o[0] <= cnt_q;
                wdata_o[0] <= '0;
                if (cnt_q == ADDR_W'(LAST_ADDR)) begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                end
            end else begin
`else
            begin
`endif
                for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
                    we_o[p] <= slot_used_c[p];
                    if (slot_used_c[p]) begin
                        waddr_o[p] <= slot_c[p].addr;
                        wdata_o[p] <= slot_c[p].data;
                    end
                end
                if (grant_any_c) begin
                    rr_ptr_q <= rr_next_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned NR = 4;
    localparam int unsigned NP = 2;
`ifdef REGFILE_INIT_SWEEP_EN
    localparam logic EXP_BUSY_RST = 1'b1;
`else
    localparam logic EXP_BUSY_RST = 1'b0;
`endif

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic [NR-1:0]            req_valid_i;
    logic [NR-1:0]            req_ready_o;
    logic [NR-1:0][4:0]       req_waddr_i;
    logic [NR-1:0][DW-1:0]    req_wdata_i;
    logic [NP-1:0][4:0]       waddr_o;
    logic [NP-1:0][DW-1:0]    wdata_o;
    logic [NP-1:0]            we_o;
    logic                     busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] rf_dut [32];

    regfile_wb_arbiter #(
        .DATA_WIDTH    (DW),
        .NR_REQ        (NR),
        .NR_WRITE_PORTS(NP)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_waddr_i(req_waddr_i),
        .req_wdata_i(req_wdata_i),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o),
        .we_o       (we_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Register file model fed by the DUT write ports.
    always @(posedge clk_i) begin
        for (int p = 0; p < int'(NP); p++) begin
            if (rst_ni && we_o[p]) rf_dut[waddr_o[p]] <= wdata_o[p];
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i = '0;
        req_waddr_i = '0;
        req_wdata_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
`ifdef REGFILE_INIT_SWEEP_EN
        repeat (31) tick();
`endif
    endtask

    task automatic test_reset();
        rst_ni      = 1'b1;
        req_valid_i = '1;
        for (int k = 0; k < int'(NR); k++) begin
            req_waddr_i[k] = 5'(k + 1);
            req_wdata_i[k] = DW'(k + 100);
        end
        #3 rst_ni = 1'b0;
        tick();
        tick();
        n_checks++; if (we_o !== '0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we_o); end
        n_checks++; if (waddr_o !== '0) begin n_fail++; $display("FAIL reset_waddr: got %h want 0", waddr_o); end
        n_checks++; if (wdata_o !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata_o); end
        n_checks++; if (req_ready_o !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready_o); end
        n_checks++; if (busy_o !== EXP_BUSY_RST) begin n_fail++; $display("FAIL reset_busy: got %b want %b", busy_o, EXP_BUSY_RST); end
        idle_inputs();
        rst_ni = 1'b1;
    endtask

`ifdef REGFILE_INIT_SWEEP_EN
    // Assumes reset was released at the start of the current cycle; x5=0xAA is pending.
    task automatic test_sweep_body(input string tag);
        for (int c = 0; c < 31; c++) begin
            @(negedge clk_i);
            n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL %s_busy c=%0d: got %b want 1", tag, c, busy_o); end
            n_checks++; if (req_ready_o !== '0) begin n_fail++; $display("FAIL %s_ready c=%0d: got %b want 0", tag, c, req_ready_o); end
            tick();
            n_checks++; if (we_o !== 2'b01) begin n_fail++; $display("FAIL %s_we c=%0d: got %b want 01", tag, c, we_o); end
            n_checks++; if (waddr_o[0] !== 5'(c + 1)) begin n_fail++; $display("FAIL %s_waddr c=%0d: got %0d want %0d", tag, c, waddr_o[0], c + 1); end
            n_checks++; if (wdata_o[0] !== '0) begin n_fail++; $display("FAIL %s_wdata c=%0d: got %h want 0", tag, c, wdata_o[0]); end
        end
        @(negedge clk_i);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s_busy_done: got %b want 0", tag, busy_o); end
        n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL %s_first_ready: got %b want 0001", tag, req_ready_o); end
        tick();
        req_valid_i = '0;
        n_checks++; if (we_o !== 2'b01 || waddr_o[0] !== 5'd5 || wdata_o[0] !== DW'(8'hAA)) begin
            n_fail++; $display("FAIL %s_first_write: got we=%b a=%0d d=%h want we=01 a=5 d=aa", tag, we_o, waddr_o[0], wdata_o[0]);
        end
    endtask

    task automatic test_sweep();
        idle_inputs();
        req_valid_i[0] = 1'b1;
        req_waddr_i[0] = 5'd5;
        req_wdata_i[0] = DW'(8'hAA);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        test_sweep_body("sweep");
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        idle_inputs();
        req_valid_i[0] = 1'b1;
        req_waddr_i[0] = 5'd5;
        req_wdata_i[0] = DW'(8'hAA);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        repeat (12) tick();
        n_checks++; if (waddr_o[0] !== 5'd12) begin n_fail++; $display("FAIL midsweep_pos: got %0d want 12", waddr_o[0]); end
        rst_ni = 1'b0;
        #1;
        n_checks++; if (we_o !== '0) begin n_fail++; $display("FAIL midsweep_we_clear: got %b want 0", we_o); end
        tick();
        rst_ni = 1'b1;
        test_sweep_body("resweep");
        idle_inputs();
    endtask
`endif

    task automatic test_round_robin();
        do_reset();
        req_valid_i = '1;
        for (int k = 0; k < int'(NR); k++) begin
            req_waddr_i[k] = 5'(k + 1);
            req_wdata_i[k] = DW'(k + 'hA0);
        end
        for (int c = 0; c < 3; c++) begin
            logic [NR-1:0] er;
            logic [4:0] ea0, ea1;
            er  = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            ea0 = (c % 2 == 0) ? 5'd1 : 5'd3;
            ea1 = (c % 2 == 0) ? 5'd2 : 5'd4;
            @(negedge clk_i);
            n_checks++; if (req_ready_o !== er) begin n_fail++; $display("FAIL rr_ready c=%0d: got %b want %b", c, req_ready_o, er); end
            tick();
            n_checks++; if (we_o !== 2'b11) begin n_fail++; $display("FAIL rr_we c=%0d: got %b want 11", c, we_o); end
            n_checks++; if (waddr_o[0] !== ea0 || waddr_o[1] !== ea1) begin
                n_fail++; $display("FAIL rr_waddr c=%0d: got %0d,%0d want %0d,%0d", c, waddr_o[0], waddr_o[1], ea0, ea1);
            end
        end
        idle_inputs();
    endtask

    task automatic test_conflict();
        do_reset();
        req_valid_i    = 4'b0011;
        req_waddr_i[0] = 5'd7; req_wdata_i[0] = DW'(8'h11);
        req_waddr_i[1] = 5'd7; req_wdata_i[1] = DW'(8'h22);
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL conf_ready0: got %b want 0001", req_ready_o); end
        tick();
        req_valid_i[0] = 1'b0;
        n_checks++; if (we_o !== 2'b01 || waddr_o[0] !== 5'd7 || wdata_o[0] !== DW'(8'h11)) begin
            n_fail++; $display("FAIL conf_write0: got we=%b a=%0d d=%h want we=01 a=7 d=11", we_o, waddr_o[0], wdata_o[0]);
        end
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL conf_ready1: got %b want 0010", req_ready_o); end
        tick();
        idle_inputs();
        n_checks++; if (we_o !== 2'b01 || waddr_o[0] !== 5'd7 || wdata_o[0] !== DW'(8'h22)) begin
            n_fail++; $display("FAIL conf_write1: got we=%b a=%0d d=%h want we=01 a=7 d=22", we_o, waddr_o[0], wdata_o[0]);
        end
        tick();
        n_checks++; if (rf_dut[7] !== DW'(8'h22)) begin n_fail++; $display("FAIL conf_final_x7: got %h want 22", rf_dut[7]); end
    endtask

    task automatic test_x0();
        do_reset();
        req_valid_i    = 4'b0101;
        req_waddr_i[0] = 5'd3; req_wdata_i[0] = DW'(8'h33);
        req_waddr_i[2] = 5'd0; req_wdata_i[2] = DW'(8'hFF);
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 4'b0101) begin n_fail++; $display("FAIL x0_ready: got %b want 0101", req_ready_o); end
        tick();
        n_checks++; if (we_o !== 2'b01 || waddr_o[0] !== 5'd3) begin n_fail++; $display("FAIL x0_write: got we=%b a=%0d want we=01 a=3", we_o, waddr_o[0]); end
        idle_inputs();
        req_valid_i    = 4'b0011;
        req_waddr_i[0] = 5'd10; req_wdata_i[0] = DW'(8'h10);
        req_waddr_i[1] = 5'd11; req_wdata_i[1] = DW'(8'h11);
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 4'b0011) begin n_fail++; $display("FAIL x0_ready2: got %b want 0011", req_ready_o); end
        tick();
        n_checks++; if (waddr_o[0] !== 5'd11 || waddr_o[1] !== 5'd10) begin
            n_fail++; $display("FAIL x0_rr_ptr: got ports %0d,%0d want 11,10", waddr_o[0], waddr_o[1]);
        end
        idle_inputs();
    endtask

    task automatic test_latency();
        do_reset();
        req_valid_i[0] = 1'b1;
        req_waddr_i[0] = 5'd9;
        req_wdata_i[0] = DW'(16'h1234);
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL lat_ready: got %b want 0001", req_ready_o); end
        tick();
        idle_inputs();
        n_checks++; if (we_o[0] !== 1'b1 || waddr_o[0] !== 5'd9) begin n_fail++; $display("FAIL lat_n1: got we=%b a=%0d want 1,9", we_o[0], waddr_o[0]); end
        tick();
        n_checks++; if (rf_dut[9] !== DW'(16'h1234)) begin n_fail++; $display("FAIL lat_n2_read: got %h want 1234", rf_dut[9]); end
    endtask

    task automatic test_back_to_back();
        int waited [NR];
        do_reset();
        req_valid_i = '1;
        for (int k = 0; k < int'(NR); k++) begin
            req_waddr_i[k] = 5'(k + 1);
            req_wdata_i[k] = DW'($urandom);
            waited[k] = 0;
        end
        for (int c = 0; c < 16; c++) begin
            logic [NR-1:0] r;
            @(negedge clk_i);
            r = req_ready_o;
            n_checks++; if ($countones(r) != int'(NP)) begin n_fail++; $display("FAIL b2b_throughput c=%0d: got %0d grants want %0d", c, $countones(r), NP); end
            for (int k = 0; k < int'(NR); k++) begin
                waited[k]++;
                if (r[k]) begin
                    n_checks++; if (waited[k] > 2) begin n_fail++; $display("FAIL b2b_starve req%0d: waited %0d cycles want <= 2", k, waited[k]); end
                    waited[k] = 0;
                end
            end
            tick();
            for (int k = 0; k < int'(NR); k++) if (r[k]) req_wdata_i[k] = DW'($urandom);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic          v [NR];
        logic [4:0]    a [NR];
        logic [DW-1:0] d [NR];
        logic [4:0]    m_waddr [NP];
        logic [DW-1:0] m_wdata [NP];
        logic [DW-1:0] rf_model [32];
        bit            written [32];
        int            rr;
        do_reset();
        rr = 0;
        for (int p = 0; p < int'(NP); p++) begin m_waddr[p] = '0; m_wdata[p] = '0; end
`ifdef REGFILE_INIT_SWEEP_EN
        m_waddr[0] = 5'd31;
`endif
        for (int i = 0; i < 32; i++) written[i] = 0;
        for (int k = 0; k < int'(NR); k++) v[k] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            int            grant_src[$];
            logic [NR-1:0] er;
            logic [NP-1:0] ewe;
            int            last;
            for (int k = 0; k < int'(NR); k++) begin
                if (!v[k] && $urandom_range(0, 9) < 6) begin
                    v[k] = 1'b1;
                    a[k] = 5'($urandom_range(0, 7));
                    d[k] = {$urandom, $urandom};
                end
                req_valid_i[k] = v[k];
                req_waddr_i[k] = a[k];
                req_wdata_i[k] = d[k];
            end
            er = '0; ewe = '0; last = -1;
            for (int j = 0; j < int'(NR); j++) begin
                int  k;
                bit  dup;
                k = (rr + j) % int'(NR);
                if (!v[k]) continue;
                if (a[k] == 5'd0) begin er[k] = 1'b1; continue; end
                dup = 0;
                foreach (grant_src[g]) if (a[grant_src[g]] == a[k]) dup = 1;
                if (!dup && grant_src.size() < int'(NP)) begin
                    grant_src.push_back(k);
                    er[k] = 1'b1;
                    last = k;
                end
            end
            foreach (grant_src[g]) begin
                ewe[g] = 1'b1;
                m_waddr[g] = a[grant_src[g]];
                m_wdata[g] = d[grant_src[g]];
            end
            if (last >= 0) rr = (last + 1) % int'(NR);
            @(negedge clk_i);
            n_checks++; if (req_ready_o !== er) begin n_fail++; $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready_o, er); end
            tick();
            n_checks++; if (we_o !== ewe) begin n_fail++; $display("FAIL rand_we c=%0d: got %b want %b", c, we_o, ewe); end
            for (int p = 0; p < int'(NP); p++) begin
                n_checks++; if (waddr_o[p] !== m_waddr[p]) begin n_fail++; $display("FAIL rand_waddr c=%0d p=%0d: got %0d want %0d", c, p, waddr_o[p], m_waddr[p]); end
                n_checks++; if (wdata_o[p] !== m_wdata[p]) begin n_fail++; $display("FAIL rand_wdata c=%0d p=%0d: got %h want %h", c, p, wdata_o[p], m_wdata[p]); end
            end
            foreach (grant_src[g]) begin
                rf_model[a[grant_src[g]]] = d[grant_src[g]];
                written[a[grant_src[g]]]  = 1;
            end
            for (int k = 0; k < int'(NR); k++) if (er[k]) v[k] = 1'b0;
        end
        idle_inputs();
        tick();
        tick();
        for (int i = 1; i < 32; i++) begin
            if (written[i]) begin
                n_checks++; if (rf_dut[i] !== rf_model[i]) begin n_fail++; $display("FAIL rand_rf x%0d: got %h want %h", i, rf_dut[i], rf_model[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_traffic();
        do_reset();
        req_valid_i = '1;
        for (int k = 0; k < int'(NR); k++) begin
            req_waddr_i[k] = 5'(k + 1);
            req_wdata_i[k] = DW'(k + 'h50);
        end
        @(negedge clk_i);
        tick();
        rst_ni = 1'b0;
        #1;
        n_checks++; if (we_o !== '0) begin n_fail++; $display("FAIL midtraffic_we: got %b want 0", we_o); end
        n_checks++; if (waddr_o !== '0) begin n_fail++; $display("FAIL midtraffic_waddr: got %h want 0", waddr_o); end
        n_checks++; if (req_ready_o !== '0) begin n_fail++; $display("FAIL midtraffic_ready: got %b want 0", req_ready_o); end
        tick();
        rst_ni = 1'b1;
`ifdef REGFILE_INIT_SWEEP_EN
        repeat (31) tick();
`endif
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 4'b0011) begin n_fail++; $display("FAIL midtraffic_rr_restart: got %b want 0011", req_ready_o); end
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
`ifdef REGFILE_INIT_SWEEP_EN
        test_sweep();
        test_reset_mid_sweep();
`endif
        test_round_robin();
        test_conflict();
        test_x0();
        test_latency();
        test_back_to_back();
        test_random();
        test_reset_mid_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and sequencer for the flip-flop integer register file. It collects write requests from `NR_REQ` producers (functional units, load unit, CSR path) and shares the register file's `NR_WRITE_PORTS` write ports between them with round-robin fairness. It never issues two same-address writes in one cycle, and drives registered `waddr/wdata/we` straight into the register file's write ports. Optionally, after reset, it sweeps every architectural register to zero before accepting traffic.

## Interface
Parameters:
- `DATA_WIDTH`, 64, width of each write datum.
- `NR_REQ`, 4, number of requesters, ≥ 1.
- `NR_WRITE_PORTS`, 2, number of register file write ports, 1 ≤ `NR_WRITE_PORTS` ≤ `NR_REQ`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NR_REQ  request valid per requester.
- `req_ready_o`  out  NR_REQ  request accepted this cycle (combinational).
- `req_waddr_i`  in  NR_REQ×5  destination register per requester.
- `req_wdata_i`  in  NR_REQ×DATA_WIDTH  write data per requester.
- `waddr_o`  out  NR_WRITE_PORTS×5  to register file `waddr_i`, registered.
- `wdata_o`  out  NR_WRITE_PORTS×DATA_WIDTH  to register file `wdata_i`, registered.
- `we_o`  out  NR_WRITE_PORTS  to register file `we_i`, registered.
- `busy_o`  out  1  init sweep in progress, so no requests are accepted.

## Operation
- FSM states: `INIT` (macro only) and `RUN`.
- Reset enters `INIT` when the macro is defined, otherwise `RUN`.
- Handshake: a request transfers when `req_valid_i[k] && req_ready_o[k]`. A requester holds valid, addr and data stable until accepted.
- Ready may depend on valid. Valid must not depend on ready.
- Grant scan in `RUN`:
  - Requesters are scanned in order `rr_ptr`, `rr_ptr+1`, … mod `NR_REQ`.
  - Each valid request is granted to the next free port slot. Ports fill in ascending index order.
  - Scanning stops when all `NR_WRITE_PORTS` slots are used.
- x0 requests (`req_waddr_i == 0`) are always accepted in `RUN`. They consume no port slot and produce no `we_o`.
- Same-address conflict: if a later-scanned valid request targets the same nonzero address as one already granted this cycle, it gets no ready and no slot. It is retried next cycle.
- `rr_ptr`:
  - After a cycle with at least one slot-consuming grant, `rr_ptr` = (last granted index + 1) mod `NR_REQ`.
  - Otherwise `rr_ptr` is unchanged.
  - x0 accepts do not move `rr_ptr`.
- Output register: each cycle, slot p loads `we_o[p]` = slot used, plus that request's addr and data.
  - Unused slots drive `we_o[p]`=0.
  - Unused slots hold their previous `waddr_o[p]` and `wdata_o[p]` values.
- `INIT` state:
  - A 5-bit counter `cnt` runs from 1 to 31.
  - Each cycle drives `we_o[0]`=1, `waddr_o[0]`=`cnt`, `wdata_o[0]`=0. Other ports have `we_o`=0.
  - All `req_ready_o`=0 and `busy_o`=1.
  - After the write with `cnt`=31 is issued, the FSM moves to `RUN`.
- Reset values: `we_o`=0, `waddr_o`=0, `wdata_o`=0, `rr_ptr`=0, `cnt`=1. `busy_o`=1 with the macro, 0 without.
- All `req_ready_o`=0 while `rst_ni` is low.

## Timing
- Accept to register file write enable: 1 cycle.
  - A request handshaken in cycle N has `we_o` high in cycle N+1.
  - The register file updates at the end of N+1, so the value is readable from N+2.
- Throughput: up to `NR_WRITE_PORTS` writes per cycle, plus any number of x0 accepts.
- Starvation bound: a continuously valid, non-conflicting requester is granted within ⌈`NR_REQ`/`NR_WRITE_PORTS`⌉ cycles.
- Init sweep:
  - `RUN` is entered 31 cycles after reset release.
  - `busy_o` falls in that same cycle, and the first accept is possible then.
- Reset asserted mid-sweep or mid-traffic: outputs clear asynchronously. The sweep restarts at `cnt`=1, and in-flight (unregistered) requests are dropped.

## Configuration
- `REGFILE_INIT_SWEEP_EN`: when defined, the `INIT` state and the 31-cycle zeroing sweep are compiled in.
  - Required when the register file's own reset of its storage is compiled out.
- When undefined: no `INIT` state and no `cnt`. The block resets directly into `RUN`, `busy_o` is tied 0, and requests are accepted from the first cycle after reset.

## Test plan
- Sweep (macro on): release reset → `busy_o`=1 for 31 cycles. Port 0 writes addr 1..31 with data 0, one per cycle, and all `req_ready_o`=0. Then `busy_o`=0, and a request to x5=0xAA is accepted the next cycle.
- Round-robin (`NR_REQ`=4, 2 ports, macro off): all four valid every cycle to x1..x4 → cycle 0 grants {0,1}, cycle 1 grants {2,3}, cycle 2 grants {0,1}. `we_o`=2'b11 one cycle after each grant.
- Same-address conflict: req0 and req1 both write x7 (0x11, 0x22), `rr_ptr`=0 → only req0 is accepted. Port 0 writes 0x11, and req1 is accepted next cycle writing 0x22. Final x7=0x22.
- x0 drop: req2 writes x0 with 0xFF while req0 writes x3 → both ready. Only one `we_o` is asserted (x3), and `rr_ptr` advances to 1.
- Latency: single request x9=0x1234 accepted in cycle N → `we_o[0]`=1, `waddr_o[0]`=9 in N+1. Register file read of x9 returns 0x1234 in N+2.
- Reset mid-sweep (macro on): assert `rst_ni` low at `cnt`=12 → `we_o` clears immediately. After release the sweep restarts at addr 1 and lasts 31 cycles.
